// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  // Default address/PC width.
  localparam int unsigned IfuWidth = 32;

  // Instruction word presented alongside an access fault.
  localparam logic [31:0] InstZero = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StOut,
    StDrain
  } ifu_state_e;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one fetch in flight, flushable at any point.
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned WIDTH = IfuWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pc_i,
  output logic             pc_we_o,
  output logic             imem_req_valid_o,
  input  logic             imem_req_ready_i,
  output logic [WIDTH-1:0] imem_req_addr_o,
  input  logic             imem_rsp_valid_i,
  input  logic [31:0]      imem_rsp_data_i,
  input  logic             imem_rsp_err_i,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [31:0]      inst_o,
  output logic [WIDTH-1:0] inst_pc_o,
  output logic             inst_fault_o,
  input  logic             flush_i
);

  ifu_state_e       state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             kill_q, kill_d;
  logic [31:0]      inst_q, inst_d;
  logic             fault_q, fault_d;

  // State and datapath registers; reset clears every visible output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      kill_q  <= 1'b0;
      inst_q  <= InstZero;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: begin
        addr_d  = pc_i;
        kill_d  = 1'b0;
        state_d = StReq;
      end
      StReq: begin
        if (imem_req_ready_i) begin
          // A flush seen now or while stalled means the response is unwanted:
          // wait for it in DRAIN so it cannot be mistaken for the next fetch.
          state_d = (flush_i || kill_q) ? StDrain : StWait;
          kill_d  = 1'b0;
        end else if (flush_i) begin
          kill_d = 1'b1;
        end
      end
      StWait: begin
        if (imem_rsp_valid_i) begin
          if (flush_i) begin
            state_d = StIdle;
          end else begin
            inst_d  = imem_rsp_err_i ? InstZero : imem_rsp_data_i;
            fault_d = imem_rsp_err_i;
            state_d = StOut;
          end
        end else if (flush_i) begin
          state_d = StDrain;
        end
      end
      StOut: begin
        if (flush_i || inst_ready_i) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (imem_rsp_valid_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    imem_req_valid_o = (state_q == StReq);
    inst_valid_o     = (state_q == StOut);
    pc_we_o          = (state_q == StOut) && inst_ready_i && !flush_i;
  end

  assign imem_req_addr_o = addr_q;
  assign inst_o          = inst_q;
  assign inst_pc_o       = addr_q;
  assign inst_fault_o    = fault_q;

endmodule
